// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Shared memory port for the multicycle CPU. Arbitrates between the
// instruction-fetch channel (IF) and the load/store channel (LS) for a single
// memory with a mem_cmd / mem_addr / w_data / r_data interface. One access is
// in flight at a time: IDLE -> RD (fetch or load) or WR (store) -> IDLE.
//
// Parameters
//   AW          address width
//   DW          data width
//   RD_LAT      cycles mem_cmd=READ is held before r_data is sampled (>= 1)
//   FETCH_PRIO  1: IF always wins a conflict, 0: round-robin between IF and LS
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   if_req     in   fetch request, held until if_gnt
//   if_addr    in   fetch address
//   if_gnt     out  fetch accepted this cycle (combinational)
//   if_rvalid  out  one-cycle pulse, if_rdata valid
//   if_rdata   out  fetched word, held until the next fetch completes
//   ls_req     in   load/store request, held until ls_gnt
//   ls_we      in   1 = store, 0 = load
//   ls_addr    in   load/store address
//   ls_wdata   in   store data
//   ls_gnt     out  load/store accepted this cycle (combinational)
//   ls_rvalid  out  one-cycle pulse, ls_rdata valid (loads only)
//   ls_rdata   out  loaded word, held until the next load completes
//   mem_cmd    out  00 NONE, 01 READ, 10 WRITE
//   mem_addr   out  registered memory address
//   w_data     out  registered memory write data
//   r_data     in   memory read data
//   busy       out  high whenever an access is in flight
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int FETCH_PRIO = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] w_data,
    input  logic [DW-1:0] r_data,
    output logic          busy
);

    localparam int              CW      = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0]   LAT_VAL = CW'(RD_LAT);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    localparam logic            CH_IF   = 1'b0;
    localparam logic            CH_LS   = 1'b1;

    localparam logic [1:0]      CMD_NONE  = 2'b00;
    localparam logic [1:0]      CMD_READ  = 2'b01;
    localparam logic [1:0]      CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    state_e        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic          owner_q,     owner_d;     // channel that owns the read in flight
    logic          rr_q,        rr_d;        // channel granted last
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] ls_rdata_q,  ls_rdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          ls_rvalid_q, ls_rvalid_d;

    // Grants are only issued in IDLE. Gating with reset makes both grants drop
    // the moment reset asserts, without waiting for a clock edge.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block can leave it unassigned and
        // infer a latch.
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (state_q == ST_IDLE && reset) begin
            if (if_req && ls_req) begin
                // Round-robin: the channel not granted last wins the tie.
                if (FETCH_PRIO != 0 || rr_q == CH_LS) begin
                    if_gnt = 1'b1;
                end else begin
                    ls_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_gnt) begin
                    state_d = ST_RD;
                    cnt_d   = LAT_VAL;
                    addr_d  = if_addr;
                    owner_d = CH_IF;
                    rr_d    = CH_IF;
                end else if (ls_gnt) begin
                    addr_d  = ls_addr;
                    owner_d = CH_LS;
                    rr_d    = CH_LS;
                    if (ls_we) begin
                        state_d = ST_WR;
                        wdata_d = ls_wdata;
                    end else begin
                        state_d = ST_RD;
                        cnt_d   = LAT_VAL;
                    end
                end
            end

            ST_RD: begin
                cnt_d = cnt_q - CNT_ONE;
                // Last wait state: sample memory into the owner's data register
                // and return to IDLE in the same cycle the rvalid pulse shows.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    if (owner_q == CH_LS) begin
                        ls_rdata_d  = r_data;
                        ls_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = r_data;
                        if_rvalid_d = 1'b1;
                    end
                end
            end

            ST_WR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= CH_IF;
            rr_q        <= CH_LS;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the values from before this clock edge.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
        end
    end

    // The command is decoded from the registered state, so it is glitch-free
    // and falls to NONE as soon as reset forces the state to IDLE.
    always_comb begin
        mem_cmd = CMD_NONE;
        case (state_q)
            ST_RD:   mem_cmd = CMD_READ;
            ST_WR:   mem_cmd = CMD_WRITE;
            default: mem_cmd = CMD_NONE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;
    assign w_data    = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Three instances of mem_access_unit, each with its own RAM model:
//   0: RD_LAT=1, FETCH_PRIO=1
//   1: RD_LAT=1, FETCH_PRIO=0
//   2: RD_LAT=3, FETCH_PRIO=0
// Read results expected from each grant are pushed to a scoreboard queue and
// popped by a monitor whenever an instance raises if_rvalid or ls_rvalid.
// Inputs change and outputs are sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int NI = 3;
    localparam int LAT_TAB  [NI] = '{1, 1, 3};
    localparam int PRIO_TAB [NI] = '{1, 0, 0};

    typedef struct packed {
        logic [1:0]    inst;
        logic          ch;      // 0 = IF, 1 = LS
        logic [DW-1:0] data;
    } sb_t;

    logic          clk;
    logic          reset;
    logic          if_req    [NI];
    logic [AW-1:0] if_addr   [NI];
    logic          if_gnt    [NI];
    logic          if_rvalid [NI];
    logic [DW-1:0] if_rdata  [NI];
    logic          ls_req    [NI];
    logic          ls_we     [NI];
    logic [AW-1:0] ls_addr   [NI];
    logic [DW-1:0] ls_wdata  [NI];
    logic          ls_gnt    [NI];
    logic          ls_rvalid [NI];
    logic [DW-1:0] ls_rdata  [NI];
    logic [1:0]    mem_cmd   [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] w_data    [NI];
    logic [DW-1:0] r_data    [NI];
    logic          busy      [NI];

    int  n_checks = 0;
    int  n_errors = 0;
    sb_t sb_q[$];

    // Initial RAM contents; address 5 holds the fetch test pattern.
    function automatic logic [DW-1:0] ram_init(input int a);
        if (a == 5) return 16'hD123;
        return DW'(a * 37 + 16'h4000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DW-1:0] ram [1 << AW];

        initial begin
            for (int i = 0; i < (1 << AW); i++) ram[i] = ram_init(i);
        end

        always @(posedge clk) begin
            if (mem_cmd[g] == 2'b10) ram[mem_addr[g]] = w_data[g];
        end

        assign r_data[g] = ram[mem_addr[g]];

        mem_access_unit #(
            .AW         (AW),
            .DW         (DW),
            .RD_LAT     (LAT_TAB[g]),
            .FETCH_PRIO (PRIO_TAB[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .ls_req    (ls_req[g]),
            .ls_we     (ls_we[g]),
            .ls_addr   (ls_addr[g]),
            .ls_wdata  (ls_wdata[g]),
            .ls_gnt    (ls_gnt[g]),
            .ls_rvalid (ls_rvalid[g]),
            .ls_rdata  (ls_rdata[g]),
            .mem_cmd   (mem_cmd[g]),
            .mem_addr  (mem_addr[g]),
            .w_data    (w_data[g]),
            .r_data    (r_data[g]),
            .busy      (busy[g])
        );
    end

    // Scoreboard monitor: every rvalid pulse must match the oldest expected
    // entry. An rvalid with nothing queued is compared against an impossible
    // entry (instance 3) so it is always reported.
    task automatic sb_pop(input int k, input logic ch, input logic [DW-1:0] data);
        sb_t obs;
        sb_t exp;
        obs = '{inst: 2'(k), ch: ch, data: data};
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        check("sb_rvalid", 32'(obs), 32'(exp));
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (if_rvalid[k]) sb_pop(k, 1'b0, if_rdata[k]);
            if (ls_rvalid[k]) sb_pop(k, 1'b1, ls_rdata[k]);
        end
    end

    task automatic sb_push(input int k, input logic ch, input logic [DW-1:0] data);
        sb_q.push_back('{inst: 2'(k), ch: ch, data: data});
    endtask

    // Raise a request at the current falling edge, wait a bounded number of
    // cycles for its grant, queue the expected read data, then drop it.
    task automatic issue(input int k, input logic ch, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] ed, input string tag);
        logic got;
        if (ch == 1'b0) begin
            if_req[k]  = 1'b1;
            if_addr[k] = a;
        end else begin
            ls_req[k]   = 1'b1;
            ls_we[k]    = we;
            ls_addr[k]  = a;
            ls_wdata[k] = wd;
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if ((ch == 1'b0) ? if_gnt[k] : ls_gnt[k]) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_gnt"}, 32'(got), 32'd1);
        if (got && !(ch && we)) sb_push(k, ch, ed);
        @(negedge clk);
        if_req[k] = 1'b0;
        ls_req[k] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && sb_q.size() != 0; c++) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int nif;
        int nls;
        int ng;
        logic got;

        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 1'b0;  if_addr[k] = '0;
            ls_req[k] = 1'b0;  ls_we[k]   = 1'b0;
            ls_addr[k] = '0;   ls_wdata[k] = '0;
        end

        // Reset state, with requests pending to show grants stay low.
        if_req[0] = 1'b1;
        ls_req[1] = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_cmd%0d", k),    32'(mem_cmd[k]),   32'd0);
            check($sformatf("rst_addr%0d", k),   32'(mem_addr[k]),  32'd0);
            check($sformatf("rst_wdata%0d", k),  32'(w_data[k]),    32'd0);
            check($sformatf("rst_busy%0d", k),   32'(busy[k]),      32'd0);
            check($sformatf("rst_gnt%0d", k),    32'({if_gnt[k], ls_gnt[k]}), 32'd0);
            check($sformatf("rst_rvalid%0d", k), 32'({if_rvalid[k], ls_rvalid[k]}), 32'd0);
            check($sformatf("rst_rdata%0d", k),  32'({if_rdata[k], ls_rdata[k]}), 32'd0);
        end
        if_req[0] = 1'b0;
        ls_req[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fetch from address 5 with one wait state (instance 0).
        if_req[0]  = 1'b1;
        if_addr[0] = 9'h005;
        #1;
        check("t2_gnt_T", 32'(if_gnt[0]), 32'd1);
        if (if_gnt[0]) sb_push(0, 1'b0, 16'hD123);
        @(negedge clk);
        if_req[0] = 1'b0;
        #1;
        check("t2_cmd_T1",    32'(mem_cmd[0]),   32'd1);
        check("t2_addr_T1",   32'(mem_addr[0]),  32'h005);
        check("t2_rvalid_T1", 32'(if_rvalid[0]), 32'd0);
        @(negedge clk);
        #1;
        check("t2_rvalid_T2", 32'(if_rvalid[0]), 32'd1);
        check("t2_rdata_T2",  32'(if_rdata[0]),  32'hD123);
        check("t2_cmd_T2",    32'(mem_cmd[0]),   32'd0);
        check("t2_busy_T2",   32'(busy[0]),      32'd0);
        @(negedge clk);
        #1;
        check("t2_rvalid_T3", 32'(if_rvalid[0]), 32'd0);
        check("t2_rdata_hold", 32'(if_rdata[0]), 32'hD123);

        // Store to the top address (instance 0), then read it back.
        @(negedge clk);
        ls_req[0]   = 1'b1;
        ls_we[0]    = 1'b1;
        ls_addr[0]  = 9'h1FF;
        ls_wdata[0] = 16'hABCD;
        #1;
        check("t3_gnt_T", 32'({if_gnt[0], ls_gnt[0]}), 32'd1);
        @(negedge clk);
        ls_req[0] = 1'b0;
        #1;
        check("t3_cmd_T1",   32'(mem_cmd[0]),  32'd2);
        check("t3_addr_T1",  32'(mem_addr[0]), 32'h1FF);
        check("t3_wdata_T1", 32'(w_data[0]),   32'hABCD);
        check("t3_busy_T1",  32'(busy[0]),     32'd1);
        @(negedge clk);
        #1;
        check("t3_cmd_T2",  32'(mem_cmd[0]), 32'd0);
        check("t3_busy_T2", 32'(busy[0]),    32'd0);
        check("t3_addr_hold", 32'(mem_addr[0]), 32'h1FF);
        @(negedge clk);
        issue(0, 1'b1, 1'b0, 9'h1FF, '0, 16'hABCD, "t3_rb");
        issue(0, 1'b0, 1'b0, 9'h0A7, '0, ram_init('h0A7), "t3_fetch");
        drain();

        // Round-robin with both channels held high (instance 1).
        @(negedge clk);
        if_req[1]  = 1'b1;  if_addr[1] = 9'h010;
        ls_req[1]  = 1'b1;  ls_we[1]   = 1'b0;  ls_addr[1] = 9'h020;
        ng = 0;
        for (int c = 0; c < 16 && ng < 4; c++) begin
            #1;
            check("t4_exclusive", 32'(if_gnt[1] & ls_gnt[1]), 32'd0);
            if (if_gnt[1] || ls_gnt[1]) begin
                check($sformatf("t4_order%0d", ng), 32'(ls_gnt[1]), 32'(ng % 2));
                sb_push(1, ls_gnt[1], ls_gnt[1] ? ram_init('h020) : ram_init('h010));
                ng++;
            end
            @(negedge clk);
        end
        check("t4_grants", 32'(ng), 32'd4);
        if_req[1] = 1'b0;
        ls_req[1] = 1'b0;
        drain();

        // Fixed fetch priority: LS starves until IF drops (instance 0).
        @(negedge clk);
        if_req[0]  = 1'b1;  if_addr[0] = 9'h040;
        ls_req[0]  = 1'b1;  ls_we[0]   = 1'b0;  ls_addr[0] = 9'h041;
        nif = 0;
        nls = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (if_gnt[0]) begin
                sb_push(0, 1'b0, ram_init('h040));
                nif++;
            end
            if (ls_gnt[0]) nls++;
            @(negedge clk);
        end
        check("t5_ls_starved", 32'(nls), 32'd0);
        check("t5_if_grants",  32'(nif), 32'd3);
        if_req[0] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (!busy[0]) begin
                check("t5_ls_gnt_first_idle", 32'(ls_gnt[0]), 32'd1);
                if (ls_gnt[0]) sb_push(0, 1'b1, ram_init('h041));
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("t5_idle_seen", 32'(got), 32'd1);
        @(negedge clk);
        ls_req[0] = 1'b0;
        drain();

        // Three wait states (instance 2).
        @(negedge clk);
        ls_req[2]  = 1'b1;  ls_we[2] = 1'b0;  ls_addr[2] = 9'h033;
        #1;
        check("t6_gnt_T", 32'(ls_gnt[2]), 32'd1);
        if (ls_gnt[2]) sb_push(2, 1'b1, ram_init('h033));
        @(negedge clk);
        ls_req[2] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("t6_cmd_T%0d", i),    32'(mem_cmd[2]),   32'd1);
            check($sformatf("t6_addr_T%0d", i),   32'(mem_addr[2]),  32'h033);
            check($sformatf("t6_rvalid_T%0d", i), 32'(ls_rvalid[2]), 32'd0);
            @(negedge clk);
        end
        #1;
        check("t6_rvalid_T4", 32'(ls_rvalid[2]), 32'd1);
        check("t6_cmd_T4",    32'(mem_cmd[2]),   32'd0);
        check("t6_busy_T4",   32'(busy[2]),      32'd0);
        drain();

        // Same load, aborted by reset at T+2: no rvalid may follow.
        @(negedge clk);
        ls_req[2]  = 1'b1;  ls_addr[2] = 9'h034;
        #1;
        check("t6r_gnt_T", 32'(ls_gnt[2]), 32'd1);
        @(negedge clk);
        ls_req[2] = 1'b0;
        #1;
        check("t6r_cmd_T1", 32'(mem_cmd[2]), 32'd1);
        @(negedge clk);
        reset     = 1'b0;
        ls_req[2] = 1'b1;
        #1;
        check("t6r_cmd_rst",    32'(mem_cmd[2]),   32'd0);
        check("t6r_busy_rst",   32'(busy[2]),      32'd0);
        check("t6r_gnt_rst",    32'(ls_gnt[2]),    32'd0);
        check("t6r_rvalid_rst", 32'(ls_rvalid[2]), 32'd0);
        @(negedge clk);
        ls_req[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) @(negedge clk);
        #1;
        check("t6r_busy_after", 32'(busy[2]),    32'd0);
        check("t6r_cmd_after",  32'(mem_cmd[2]), 32'd0);
        drain();

        // Round-robin state restarts from reset: IF wins the first tie again.
        @(negedge clk);
        if_req[2] = 1'b1;  if_addr[2] = 9'h100;
        ls_req[2] = 1'b1;  ls_addr[2] = 9'h101;
        #1;
        check("t7_first_tie", 32'({if_gnt[2], ls_gnt[2]}), 32'd2);
        if (if_gnt[2]) sb_push(2, 1'b0, ram_init('h100));
        @(negedge clk);
        if_req[2] = 1'b0;
        ls_req[2] = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
